// File: rtl/set_bit_serializer.sv
// set_bit_serializer: takes a vector over valid/ready and emits one beat per
// set bit, lowest index first. Each beat carries the one-hot of the bit, its
// binary index and a last flag. The residual register is the only state; the
// beat presented downstream is always the lowest bit still set in it.

// first_one: isolates the lowest set bit of a vector (bit 0 highest priority).
// "small" is a plain ripple chain; "fast" uses the two's-complement trick,
// which maps onto the carry chain. Both produce the same one-hot.
module first_one #(
  parameter int    WIDTH   = 8,
  parameter string VARIANT = "fast"
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot
);

  generate
    if (VARIANT == "small") begin : g_small
      // w_seen[i] is high when some bit below i is set
      logic [WIDTH-1:0] w_seen;

      assign w_seen[0] = 1'b0;
      for (genvar i = 1; i < WIDTH; i++) begin : g_seen
        assign w_seen[i] = w_seen[i-1] | i_vec[i-1];
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_onehot[i] = i_vec[i] & ~w_seen[i];
      end
    end else begin : g_fast
      // x & -x keeps only the lowest set bit
      assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
    end
  endgenerate

endmodule

module set_bit_serializer #(
  parameter int    WIDTH   = 8,
  parameter string VARIANT = "fast",
  localparam int   INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_onehot,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last
);

  // IDLE/BUSY is fully implied by the residual; the enum just names it
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  logic [WIDTH-1:0]       r_resid;
  logic [WIDTH-1:0]       w_resid_nxt;
  logic [WIDTH-1:0]       w_onehot;
  logic [WIDTH-1:0]       w_rest;
  logic [INDEX_WIDTH-1:0] w_index;
  logic                   w_last;
  logic                   w_in_fire;
  logic                   w_out_fire;
  state_t                 w_state;

  first_one #(
    .WIDTH   (WIDTH),
    .VARIANT (VARIANT)
  ) u_first_one (
    .i_vec    (r_resid),
    .o_onehot (w_onehot)
  );

  // Binary encode of the one-hot; stays zero when nothing is set
  always_comb begin
    w_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_onehot[i]) w_index = w_index | INDEX_WIDTH'(i);
    end
  end

  // Decode state, handshakes and the next residual value
  always_comb begin
    w_state     = (r_resid != '0) ? ST_BUSY : ST_IDLE;
    w_rest      = r_resid & ~w_onehot;
    w_last      = (w_state == ST_BUSY) && (w_rest == '0);
    w_out_fire  = 1'b0;
    w_in_fire   = 1'b0;
    w_resid_nxt = r_resid;

    // A new vector may enter when idle, or when the final beat leaves this
    // cycle, which keeps consecutive vectors bubble-free.
    unique case (w_state)
      ST_IDLE: begin
        w_in_fire = !reset && in_valid;
      end
      ST_BUSY: begin
        w_out_fire = !reset && out_ready;
        w_in_fire  = !reset && in_valid && out_ready && w_last;
      end
      default: ;
    endcase

    // Loading a new vector wins over retiring the current bit
    if (w_in_fire)       w_resid_nxt = in_data;
    else if (w_out_fire) w_resid_nxt = w_rest;
  end

  // Residual register; reset drops any partially sent vector
  always_ff @(posedge clock) begin
    if (reset) r_resid <= '0;
    else       r_resid <= w_resid_nxt;
  end

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    in_ready   = !reset && ((w_state == ST_IDLE) || (out_ready && w_last));
    out_valid  = !reset && (w_state == ST_BUSY);
    out_onehot = reset ? '0 : w_onehot;
    out_index  = reset ? '0 : w_index;
    out_last   = !reset && w_last;
  end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Bench for set_bit_serializer: both VARIANTs run side by side on the same
// stimulus. Stimulus pushes expected beats into a shared queue; a monitor
// walks that queue separately for each instance as beats are accepted.
module tb_set_bit_serializer;

  typedef struct {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       last;
    logic       contig;  // beat must follow the previous accepted beat directly
  } beat_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic [1:0] ir, ov, ol;
  logic [7:0] oh  [2];
  logic [2:0] idx [2];

  beat_t exp_q[$];
  int    rd [2];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  set_bit_serializer #(.WIDTH(8), .VARIANT("fast")) u_fast (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_onehot(oh[0]), .out_index(idx[0]), .out_last(ol[0])
  );

  set_bit_serializer #(.WIDTH(8), .VARIANT("small")) u_small (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_onehot(oh[1]), .out_index(idx[1]), .out_last(ol[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beats of a vector: each set bit, low to high
  task automatic push_vec(input logic [7:0] v, input logic c_first, input logic c_rest);
    beat_t b;
    logic  first = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        b.oh     = 8'h01 << i;
        b.idx    = 3'(i);
        b.last   = ((v >> i) == 8'h01);
        b.contig = first ? c_first : c_rest;
        first    = 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  // Called just after a rising edge; leaves in_valid high with v on return
  task automatic send(input logic [7:0] v, input logic c_first, input logic c_rest);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clock);
      if (ir[0]) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    if (ir[0]) push_vec(v, c_first, c_rest);
    @(posedge clock); #1;
  endtask

  // Wait until every expected beat has been seen by both instances
  task automatic wait_drain;
    int n = 0;
    while ((rd[0] != exp_q.size() || rd[1] != exp_q.size()) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_fast", 32'(rd[0]), 32'(exp_q.size()));
    chk("drain_small", 32'(rd[1]), 32'(exp_q.size()));
    @(posedge clock); #1;
  endtask

  // Monitor: compare accepted beats, hold stability during stalls
  initial begin
    logic       st_prev [2];
    logic [7:0] h_oh    [2];
    logic [2:0] h_idx   [2];
    logic       h_last  [2];
    int         last_cyc[2];
    beat_t      e;
    for (int k = 0; k < 2; k++) begin
      st_prev[k] = 1'b0; rd[k] = 0; last_cyc[k] = -10;
    end
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          if (st_prev[k]) begin
            chk("stall_onehot", 32'(oh[k]), 32'(h_oh[k]));
            chk("stall_index", 32'(idx[k]), 32'(h_idx[k]));
            chk("stall_last", 32'(ol[k]), 32'(h_last[k]));
          end
          if (out_ready) begin
            st_prev[k] = 1'b0;
            if (rd[k] >= exp_q.size()) begin
              chk("unexpected_beat", 32'(rd[k]), 32'(exp_q.size()));
            end else begin
              e = exp_q[rd[k]];
              chk("onehot", 32'(oh[k]), 32'(e.oh));
              chk("index", 32'(idx[k]), 32'(e.idx));
              chk("last", 32'(ol[k]), 32'(e.last));
              chk("in_ready_on_beat", 32'(ir[k]), 32'(e.last));
              if (e.contig) chk("no_bubble", 32'(cyc), 32'(last_cyc[k] + 1));
              last_cyc[k] = cyc;
              rd[k]++;
            end
          end else begin
            chk("in_ready_stall", 32'(ir[k]), 32'd0);
            st_prev[k] = 1'b1;
            h_oh[k]    = oh[k];
            h_idx[k]   = idx[k];
            h_last[k]  = ol[k];
          end
        end else begin
          st_prev[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [6:0] pat;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_ready", 32'(ir), 32'd0);
    chk("rst_onehot", 32'(oh[0] | oh[1]), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 32'(ir), 32'h3);
    chk("post_rst_valid", 32'(ov), 32'd0);
    @(posedge clock); #1;

    // 8'b1010_0110 at full rate: idx 1,2,5,7
    send(8'hA6, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("latency_valid", 32'(ov), 32'h3);
    chk("latency_index", 32'(idx[0]), 32'd1);
    wait_drain();

    // Same vector with out_ready toggling 1,0,0,1,1,0,1
    send(8'hA6, 1'b0, 1'b0);
    in_valid = 1'b0;
    pat = 7'b1011001;  // bit 0 first
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back: 8'h81 then 8'h10 with no bubble
    send(8'h81, 1'b0, 1'b1);
    send(8'h10, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Zero vector produces no beat and keeps in_ready high
    send(8'h00, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("zero_ready", 32'(ir), 32'h3);
    chk("zero_valid", 32'(ov), 32'd0);
    @(posedge clock); #1;
    send(8'h08, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("single3_index", 32'(idx[1]), 32'd3);
    chk("single3_last", 32'(ol), 32'h3);
    wait_drain();

    // Reset mid-vector after two beats
    send(8'hFF, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", 32'(ov), 32'd0);
    chk("midrst_ready", 32'(ir), 32'd0);
    chk("midrst_beats", 32'(rd[0]), 32'(exp_q.size() - 6));
    @(posedge clock); #1;
    reset = 1'b0;
    rd[0] = exp_q.size();
    rd[1] = exp_q.size();
    @(negedge clock);
    chk("midrst_after_ready", 32'(ir), 32'h3);
    chk("midrst_after_valid", 32'(ov), 32'd0);
    repeat (4) @(posedge clock);
    #1;

    // Full and single-bit vectors
    send(8'hFF, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    send(8'h80, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("single7_index", 32'(idx[0]), 32'd7);
    chk("single7_onehot", 32'(oh[1]), 32'h80);
    wait_drain();

    repeat (3) @(posedge clock);
    chk("final_idle", 32'(ov), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/set_bit_serializer.md
Name: set_bit_serializer

Overview:
- Accepts a WIDTH-bit vector over a valid/ready handshake.
- Emits one output beat per set bit, lowest index first. Each beat carries the one-hot of that bit, its binary index and a last flag.
- Sits downstream of a first_one instance, which it contains and drives from its internal residual-vector register.
- Typical consumers: interrupt/request dispatch, scoreboard-release walkers, multi-grant sequencing.

Parameters:
- WIDTH, 8, width of input vector and one-hot output; must be >= 2.
- VARIANT, "fast", passed unchanged to the internal first_one ("small" or "fast").
- INDEX_WIDTH (localparam), $clog2(WIDTH), width of out_index.

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  WIDTH  vector to serialize
- out_valid  output  1  current beat valid
- out_ready  input  1  downstream accepts current beat
- out_onehot  output  WIDTH  one-hot of lowest remaining set bit
- out_index  output  INDEX_WIDTH  binary index of that bit
- out_last  output  1  current beat is the final set bit of the vector

Behaviour:
- State: residual register R[WIDTH-1:0]. Two states derived from R:
  - IDLE: R == 0.
  - BUSY: R != 0.
- Reset (reset=1 at a rising edge): R <= 0.
  - While reset is high, in_ready=0, out_valid=0, out_onehot=0, out_index=0, out_last=0.
  - Reset mid-vector discards the remaining bits; no further beats are emitted for that vector.
- Combinational outputs from R:
  - out_onehot = first_one(R), bit 0 highest priority.
  - out_index = binary encode of out_onehot; 0 when R == 0.
  - out_valid = (R != 0).
  - out_last = out_valid && ((R & ~out_onehot) == 0).
  - All outputs are zero in IDLE.
- Input handshake:
  - in_ready = !reset && (R == 0 || (out_valid && out_ready && out_last)).
  - in_ready does not depend combinationally on in_valid.
  - Input handshake = in_valid && in_ready; R <= in_data.
  - Latency: the first beat of an accepted vector is valid the cycle after acceptance.
- Output handshake without a simultaneous input handshake: out_valid && out_ready causes R <= R & ~out_onehot.
- Simultaneous last-beat handshake and input handshake: the input load takes priority (R <= in_data). This gives back-to-back vectors with no bubble.
- Zero vector: in_data == 0 is accepted and produces no beats; the block stays IDLE and in_ready stays high.
- Stall (out_valid=1, out_ready=0): R, out_onehot, out_index and out_last are held stable; in_ready=0.
- Throughput: one beat per cycle while out_ready=1. A vector with k set bits occupies k cycles.
- in_data is sampled only on an input handshake. Changes to in_data while in_ready=0 have no effect.
- No X propagation: all outputs are defined from R only.

Test Plan:
- WIDTH=8, reset, load in_data=8'b1010_0110, out_ready=1 -> beats on cycles 1..4: onehot 0x02/idx1, 0x04/idx2, 0x20/idx5, 0x80/idx7 with last=1 on the 4th beat; in_ready high in the 4th-beat cycle.
- Same vector with out_ready toggling 1,0,0,1,1,0,1 -> each beat held stable while stalled; same 4 beats in order; no duplicates or drops.
- Back-to-back: load 8'h81, then hold in_valid with 8'h10 -> beats idx0, idx7(last), then idx4(last) on the next cycle with no bubble.
- Zero vector: load 8'h00, then 8'h08 -> no beat for the zero vector; in_ready stays 1; next cycle one beat idx3, last=1.
- Reset mid-vector: load 8'hFF, accept 2 beats, assert reset one cycle -> out_valid=0 and in_ready=0 during reset; after release in_ready=1 and no residual beats.
- Full and single-bit vectors, both VARIANTs: 8'hFF -> 8 beats idx0..7, last only on idx7. 8'h80 -> single beat idx7, last=1. Results must be identical for VARIANT="small" and "fast".
